// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list that sits directly upstream of rename. It
//   hands out up to two new destination physical registers per cycle, takes
//   back the old destination registers of committing instructions, and on
//   flush rewinds its speculative pop pointer to the committed pop pointer.
//
// Ports
//   clk                  in   clock, all state updates on the rising edge
//   rst                  in   asynchronous active-low reset
//   flush                in   mispredict/exception recovery
//   free_list_valid      in   [1:0] allocate request, bit0 = slot 0, bit1 = slot 1
//   rd_phy_new_0         out  register granted to slot 0 (combinational)
//   rd_phy_new_1         out  register granted to slot 1 (combinational)
//   fl_stall             out  fewer than two free entries
//   free_count           out  speculative free entries (tail - head)
//   commit_valid         in   [1:0] committing allocating instruction per slot
//   commit_rd_phy_old_0  in   old mapping reclaimed by commit slot 0
//   commit_rd_phy_old_1  in   old mapping reclaimed by commit slot 1
//   fl_error             out  sticky over-allocation / overflow flag
// -----------------------------------------------------------------------------
module free_list #(
    parameter int PHY_REGS  = 64,
    parameter int ARCH_REGS = 32,
    parameter int PHY_WIDTH = 6,
    parameter int FL_DEPTH  = PHY_REGS - ARCH_REGS,
    parameter int PTR_WIDTH = $clog2(FL_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           free_list_valid,
    output logic [PHY_WIDTH-1:0] rd_phy_new_0,
    output logic [PHY_WIDTH-1:0] rd_phy_new_1,
    output logic                 fl_stall,
    output logic [PTR_WIDTH-1:0] free_count,
    input  logic [1:0]           commit_valid,
    input  logic [PHY_WIDTH-1:0] commit_rd_phy_old_0,
    input  logic [PHY_WIDTH-1:0] commit_rd_phy_old_1,
    output logic                 fl_error
);

    localparam int IDX_W = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] DEPTH_PTR = PTR_WIDTH'(FL_DEPTH);
    localparam logic [PTR_WIDTH-1:0] ONE_PTR   = PTR_WIDTH'(1);

    function automatic logic [PTR_WIDTH-1:0] popcnt2(input logic [1:0] v);
        logic [PTR_WIDTH-1:0] r;
        r    = '0;
        r[0] = v[0] ^ v[1];
        r[1] = v[0] & v[1];
        return r;
    endfunction

    logic [PHY_WIDTH-1:0] list_q [FL_DEPTH];
    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [PTR_WIDTH-1:0] arch_head_q, arch_head_d;
    logic                 err_q, err_d;

    logic [PTR_WIDTH-1:0] pops;
    logic [PTR_WIDTH-1:0] head_p1;
    logic                 alloc_ok;
    logic                 alloc_err;
    logic                 push0_en, push1_en;
    logic [IDX_W-1:0]     push0_idx, push1_idx;
    logic                 ovf;

    // Grant path: always read from the registered head, so entries pushed in
    // this same cycle can never be handed out before the next cycle.
    assign free_count   = tail_q - head_q;
    assign fl_stall     = (free_count < PTR_WIDTH'(2));
    assign head_p1      = head_q + PTR_WIDTH'(free_list_valid[0]);
    assign rd_phy_new_0 = list_q[head_q[IDX_W-1:0]];
    assign rd_phy_new_1 = list_q[head_p1[IDX_W-1:0]];
    assign fl_error     = err_q;

    always_comb begin
        pops        = popcnt2(free_list_valid);
        alloc_ok    = 1'b0;
        alloc_err   = 1'b0;
        tail_d      = tail_q;
        arch_head_d = arch_head_q;
        head_d      = head_q;
        push0_en    = 1'b0;
        push1_en    = 1'b0;
        push0_idx   = '0;
        push1_idx   = '0;
        ovf         = 1'b0;

        // Allocation requests are meaningless during recovery and are dropped.
        if (!flush) begin
            if (pops > free_count) begin
                alloc_err = 1'b1;
            end else begin
                alloc_ok = 1'b1;
            end
        end

        // Each committing instruction first retires the committed entry it
        // consumed (arch_head advance), then returns its old mapping. Slots
        // are handled in order so slot 1 sees slot 0's effect on tail.
        if (commit_valid[0]) begin
            arch_head_d = arch_head_d + ONE_PTR;
            if ((tail_d - arch_head_d) == DEPTH_PTR) begin
                ovf = 1'b1;
            end else begin
                push0_en  = 1'b1;
                push0_idx = tail_d[IDX_W-1:0];
                tail_d    = tail_d + ONE_PTR;
            end
        end
        if (commit_valid[1]) begin
            arch_head_d = arch_head_d + ONE_PTR;
            if ((tail_d - arch_head_d) == DEPTH_PTR) begin
                ovf = 1'b1;
            end else begin
                push1_en  = 1'b1;
                push1_idx = tail_d[IDX_W-1:0];
                tail_d    = tail_d + ONE_PTR;
            end
        end

        // On flush the speculative pointer rewinds to the committed pointer
        // including any commits retiring in this very cycle.
        if (flush) begin
            head_d = arch_head_d;
        end else if (alloc_ok) begin
            head_d = head_q + pops;
        end

        err_d = err_q | alloc_err | ovf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                list_q[IDX_W'(i)] <= PHY_WIDTH'(ARCH_REGS + i);
            end
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= DEPTH_PTR;
            err_q       <= 1'b0;
        end else begin
            if (push0_en) begin
                list_q[push0_idx] <= commit_rd_phy_old_0;
            end
            if (push1_en) begin
                list_q[push1_idx] <= commit_rd_phy_old_1;
            end
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] free_list_valid = 2'b00;
    logic [5:0] rd_phy_new_0;
    logic [5:0] rd_phy_new_1;
    logic       fl_stall;
    logic [5:0] free_count;
    logic [1:0] commit_valid = 2'b00;
    logic [5:0] commit_rd_phy_old_0 = '0;
    logic [5:0] commit_rd_phy_old_1 = '0;
    logic       fl_error;

    int pass_cnt  = 0;
    int total_cnt = 0;

    free_list dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .free_list_valid     (free_list_valid),
        .rd_phy_new_0        (rd_phy_new_0),
        .rd_phy_new_1        (rd_phy_new_1),
        .fl_stall            (fl_stall),
        .free_count          (free_count),
        .commit_valid        (commit_valid),
        .commit_rd_phy_old_0 (commit_rd_phy_old_0),
        .commit_rd_phy_old_1 (commit_rd_phy_old_1),
        .fl_error            (fl_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_b;
        logic [1:0] fv;
        logic [1:0] cv;
        logic [5:0] o0;
        logic [5:0] o1;
        logic       fl;
        logic [5:0] e0;
        logic [5:0] e1;
        logic [5:0] ecnt;
        logic       estall;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic [5:0] e0;
        logic [5:0] e1;
        logic [5:0] ecnt;
        logic       estall;
        logic       eerr;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[15];

    function automatic vec_t mk(input logic rb, input logic [1:0] fv, input logic [1:0] cv,
                                input int o0, input int o1, input logic fl,
                                input int e0, input int e1, input int ecnt,
                                input logic es, input logic ee);
        vec_t v;
        v.rst_b = rb;  v.fv = fv;  v.cv = cv;
        v.o0 = 6'(o0); v.o1 = 6'(o1); v.fl = fl;
        v.e0 = 6'(e0); v.e1 = 6'(e1); v.ecnt = 6'(ecnt);
        v.estall = es; v.eerr = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        flush = 1'b0;
        free_list_valid = 2'b00;
        commit_valid = 2'b00;
        commit_rd_phy_old_0 = '0;
        commit_rd_phy_old_1 = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the
    // falling edge, then let the rising edge commit the state change.
    task automatic do_cycle(input string tag, input vec_t v);
        exp_t e;
        free_list_valid     = v.fv;
        commit_valid        = v.cv;
        commit_rd_phy_old_0 = v.o0;
        commit_rd_phy_old_1 = v.o1;
        flush               = v.fl;
        e.e0 = v.e0; e.e1 = v.e1; e.ecnt = v.ecnt; e.estall = v.estall; e.eerr = v.eerr;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " new0"},  32'(rd_phy_new_0), 32'(e.e0));
            check({tag, " new1"},  32'(rd_phy_new_1), 32'(e.e1));
            check({tag, " count"}, 32'(free_count),   32'(e.ecnt));
            check({tag, " stall"}, 32'(fl_stall),     32'(e.estall));
            check({tag, " error"}, 32'(fl_error),     32'(e.eerr));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // rst fv cv o0 o1 fl  e0 e1 cnt stall err
        tbl[0]  = mk(1, 2'b00, 2'b00, 0, 0, 0,  32, 32, 32, 0, 0);
        tbl[1]  = mk(0, 2'b11, 2'b00, 0, 0, 0,  32, 33, 32, 0, 0);
        tbl[2]  = mk(0, 2'b11, 2'b00, 0, 0, 0,  34, 35, 30, 0, 0);
        tbl[3]  = mk(0, 2'b11, 2'b00, 0, 0, 0,  36, 37, 28, 0, 0);
        tbl[4]  = mk(0, 2'b00, 2'b00, 0, 0, 0,  38, 38, 26, 0, 0);
        tbl[5]  = mk(1, 2'b10, 2'b00, 0, 0, 0,  32, 32, 32, 0, 0);
        tbl[6]  = mk(0, 2'b00, 2'b00, 0, 0, 0,  33, 33, 31, 0, 0);
        tbl[7]  = mk(1, 2'b11, 2'b00, 0, 0, 0,  32, 33, 32, 0, 0);
        tbl[8]  = mk(0, 2'b11, 2'b00, 0, 0, 0,  34, 35, 30, 0, 0);
        tbl[9]  = mk(0, 2'b00, 2'b01, 9, 0, 0,  36, 36, 28, 0, 0);
        tbl[10] = mk(0, 2'b11, 2'b00, 0, 0, 1,  36, 37, 29, 0, 0);
        tbl[11] = mk(0, 2'b00, 2'b00, 0, 0, 0,  33, 33, 32, 0, 0);
        tbl[12] = mk(0, 2'b11, 2'b00, 0, 0, 0,  33, 34, 32, 0, 0);
        tbl[13] = mk(0, 2'b00, 2'b11, 11, 12, 1, 35, 35, 30, 0, 0);
        tbl[14] = mk(0, 2'b00, 2'b00, 0, 0, 0,  35, 35, 32, 0, 0);

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst_b) apply_reset();
            do_cycle($sformatf("vec%0d", i), tbl[i]);
        end

        // Drain to two entries, then allocate and commit together across the wrap.
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            c = 32 - 2 * k;
            do_cycle($sformatf("wrap_alloc%0d", k),
                     mk(0, 2'b11, 2'b00, 0, 0, 0, 32 + 2 * k, 33 + 2 * k, c, (c < 2), 0));
        end
        do_cycle("wrap_both",  mk(0, 2'b11, 2'b11, 5, 7, 0, 62, 63, 2, 0, 0));
        do_cycle("wrap_grant", mk(0, 2'b11, 2'b00, 0, 0, 0, 5, 7, 2, 0, 0));
        do_cycle("wrap_empty", mk(0, 2'b00, 2'b00, 0, 0, 0, 34, 34, 0, 1, 0));

        // Empty the list, over-allocate, check stickiness, then async reset.
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            c = 32 - 2 * k;
            do_cycle($sformatf("drain%0d", k),
                     mk(0, 2'b11, 2'b00, 0, 0, 0, 32 + 2 * k, 33 + 2 * k, c, (c < 2), 0));
        end
        do_cycle("over_req",   mk(0, 2'b01, 2'b00, 0, 0, 0, 32, 33, 0, 1, 0));
        do_cycle("err_set",    mk(0, 2'b00, 2'b00, 0, 0, 0, 32, 32, 0, 1, 1));
        do_cycle("err_sticky", mk(0, 2'b00, 2'b00, 0, 0, 0, 32, 32, 0, 1, 1));

        #2 rst = 1'b0;
        #1;
        check("async_rst count", 32'(free_count),   32'd32);
        check("async_rst new0",  32'(rd_phy_new_0), 32'd32);
        check("async_rst new1",  32'(rd_phy_new_1), 32'd32);
        check("async_rst stall", 32'(fl_stall),     32'd0);
        check("async_rst error", 32'(fl_error),     32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        do_cycle("post_rst", mk(0, 2'b11, 2'b00, 0, 0, 0, 32, 33, 32, 0, 0));
        do_cycle("post_rst2", mk(0, 2'b00, 2'b00, 0, 0, 0, 34, 34, 30, 0, 0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
